// File: rtl/reg_reset_pkg.sv
// Shared defaults and helpers for the reg_reset register slice.
package reg_reset_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = 8'd0;

    // Widest vector parity_of accepts; callers zero-extend, which leaves parity unchanged.
    localparam int PARITY_MAX_WIDTH = 256;

    // Even parity (XOR reduction) of a zero-extended vector.
    function automatic logic parity_of(input logic [PARITY_MAX_WIDTH-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/reg_reset_bit.sv
// Single flop cell with synchronous, active-high reset to a per-instance value.
module reg_reset_bit (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next value when not in reset is simply the data input.
    always_comb begin
        q_d = d;
    end

    // Reset is sampled only on the rising edge and wins over data.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reg_reset.sv
// WIDTH-bit D register with synchronous active-high reset, built from reg_reset_bit cells.
// Optional registered even-parity output enabled by defining REG_RESET_PARITY_EN.
module reg_reset
    import reg_reset_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic [WIDTH-1:0] d_amisha,
    output logic [WIDTH-1:0] q_amisha
`ifdef REG_RESET_PARITY_EN
    ,
    output logic             q_parity_amisha
`endif
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            reg_reset_bit u_bit (
                .clk     (clk_amisha),
                .rst     (reset_amisha),
                .rst_val (RESET_VALUE[i]),
                .d       (d_amisha[i]),
                .q       (q_amisha[i])
            );
        end
    endgenerate

`ifdef REG_RESET_PARITY_EN
    localparam logic RESET_PARITY = parity_of(PARITY_MAX_WIDTH'(RESET_VALUE));

    logic parity_d;

    // Parity of the incoming data, registered alongside q so it always matches ^q.
    always_comb begin
        parity_d = parity_of(PARITY_MAX_WIDTH'(d_amisha));
    end

    reg_reset_bit u_parity (
        .clk     (clk_amisha),
        .rst     (reset_amisha),
        .rst_val (RESET_PARITY),
        .d       (parity_d),
        .q       (q_parity_amisha)
    );
`endif

endmodule

// File: tb/tb_reg_reset.sv
// Scoreboard bench for reg_reset: directed edge/phase cases followed by random traffic.
module tb_reg_reset;
    import reg_reset_pkg::*;

    localparam int         W  = 8;
    localparam logic [W-1:0] RV = '0;

    logic         clk;
    logic         reset;
    logic [W-1:0] d;
    logic [W-1:0] q;
`ifdef REG_RESET_PARITY_EN
    logic         qp;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic         p;
    } exp_t;

    exp_t         sb[$];
    exp_t         last_exp;
    int           n_cmp = 0;
    int           n_bad = 0;

    reg_reset #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk_amisha      (clk),
        .reset_amisha    (reset),
        .d_amisha        (d),
        .q_amisha        (q)
`ifdef REG_RESET_PARITY_EN
        ,
        .q_parity_amisha (qp)
`endif
    );

    // Reference model: on each rising edge the register should hold RV under reset, else d.
    always @(posedge clk) begin
        exp_t e;
        e.q = reset ? RV : d;
        e.p = 1'($countones(e.q) % 2);
        sb.push_back(e);
        last_exp = e;
    end

    // Monitor: shortly after every rising edge, pop the expectation and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: no expectation queued at t=%0t", $time);
        end else begin
            e = sb.pop_front();
            if (q !== e.q) begin
                n_bad++;
                $display("FAIL q_edge: got %0d expected %0d at t=%0t", q, e.q, $time);
            end
`ifdef REG_RESET_PARITY_EN
            n_cmp++;
            if (qp !== e.p) begin
                n_bad++;
                $display("FAIL parity_edge: got %0b expected %0b at t=%0t", qp, e.p, $time);
            end
            n_cmp++;
            if (qp !== parity_of(PARITY_MAX_WIDTH'(q))) begin
                n_bad++;
                $display("FAIL parity_invariant: parity %0b q %0h at t=%0t", qp, q, $time);
            end
`endif
        end
    end

    // Between edges q must keep the value captured on the last rising edge.
    task automatic check_hold(input string name);
        n_cmp++;
        if (q !== last_exp.q) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (held) at t=%0t", name, q, last_exp.q, $time);
        end
    endtask

    task automatic edge_with(input logic r, input logic [W-1:0] dv);
        reset = r;
        d     = dv;
        #10 clk = 1'b1;
        #10 clk = 1'b0;
        #5;
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        d     = '0;
        #200;
        d     = 8'd5;
        reset = 1'b0;
        #10 clk = 1'b1;                 // first edge: q = 5
        #10 reset = 1'b1; d = 8'd25;    // clock held high
        #10 d = 8'd30; reset = 1'b0;
        #10 check_hold("hold_high_reset");
        d = 8'd44;
        clk = 1'b0;                     // falling edge must do nothing
        #10 check_hold("falling_edge");
        d = 8'd58;
        #10 clk = 1'b1;                 // q = 58
        #10 clk = 1'b0;
        reset = 1'b1; d = 8'd61;
        #10 check_hold("reset_between_edges");
        d = 8'd76;
        #10 clk = 1'b1;                 // reset edge: q = 0
        #10 clk = 1'b0;
        #5;
        edge_with(1'b0, 8'd128);
        edge_with(1'b0, 8'd255);
        edge_with(1'b0, 8'h07);
        edge_with(1'b0, 8'h03);
        edge_with(1'b1, 8'hA5);
        edge_with(1'b0, 8'h00);
        for (int k = 0; k < 300; k++) begin
            edge_with(($urandom_range(0, 9) == 0), W'($urandom));
            if (($urandom_range(0, 7) == 0)) begin
                reset = 1'b1;
                d     = W'($urandom);
                #3 check_hold("random_hold");
            end
        end
        #5;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d entries remain, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
